// File: rtl/vsq_pkg.sv
// Shared constants and state encoding for the VSQ row buffer and its quantizer.
// Optional overflow flag in vsq_buffer is enabled with `define VSQ_BUF_OVF_EN.
package vsq_pkg;

    localparam int LANES = 16;
    localparam int DW    = 40;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vsq_rowmem.sv
// Row array for one VSQ block: one synchronous write port, one combinational read port.
module vsq_rowmem #(
    parameter int DEPTH = 64,
    parameter int W     = 640,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; a reset port would turn the array
    // into a huge bank of resettable flops instead of a RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/vsq_buffer.sv
// Block buffer feeding the VSQ quantizer: fills DEPTH rows, pulses o_start, then holds off while the quantizer drains.
// Define VSQ_BUF_OVF_EN to add the sticky o_ovf flag for rows offered while not ready.
module vsq_buffer
    import vsq_pkg::*;
#(
    parameter int LANES = vsq_pkg::LANES,
    parameter int DW    = vsq_pkg::DW,
    parameter int DEPTH = vsq_pkg::DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [LANES*DW-1:0]        i_data,
    output logic                       o_ready,
    output logic [LANES*DW-1:0]        o_max_data,
    output logic                       o_start,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [LANES*DW-1:0]        o_rd_data,
    output logic                       o_busy
`ifdef VSQ_BUF_OVF_EN
    ,
    output logic                       o_ovf
`endif
);

    localparam int W  = LANES * DW;
    localparam int AW = $clog2(DEPTH);

    state_t        state, state_nx;
    logic [AW-1:0] wr_cnt, wr_cnt_nx;
    logic [AW-1:0] drain_cnt, drain_cnt_nx;
    logic          start_nx;
    logic          accept;
    logic          last_row;

    // Ready is also masked by reset so nothing is accepted while the block is being discarded.
    assign o_ready    = (state == S_FILL) && !i_rst;
    assign accept     = i_valid && o_ready;
    assign last_row   = accept && (wr_cnt == AW'(DEPTH - 1));
    assign o_max_data = accept ? i_data : '0;
    assign o_busy     = (state != S_FILL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_FILL;
            wr_cnt    <= '0;
            drain_cnt <= '0;
            o_start   <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_cnt    <= wr_cnt_nx;
            drain_cnt <= drain_cnt_nx;
            o_start   <= start_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        wr_cnt_nx    = wr_cnt;
        drain_cnt_nx = drain_cnt;
        start_nx     = 1'b0;
        case (state)
            S_FILL: begin
                if (last_row) begin
                    wr_cnt_nx = '0;
                    state_nx  = S_START;
                    start_nx  = 1'b1;
                end else if (accept) begin
                    wr_cnt_nx = wr_cnt + AW'(1);
                end
            end
            S_START: begin
                state_nx     = S_DRAIN;
                drain_cnt_nx = '0;
            end
            S_DRAIN: begin
                if (drain_cnt == AW'(DEPTH - 1)) begin
                    drain_cnt_nx = '0;
                    state_nx     = S_FILL;
                end else begin
                    drain_cnt_nx = drain_cnt + AW'(1);
                end
            end
            default: begin
                state_nx = S_FILL;
            end
        endcase
    end

`ifdef VSQ_BUF_OVF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (i_valid && !o_ready) begin
            o_ovf <= 1'b1;
        end
    end
`endif

    vsq_rowmem #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (AW)
    ) u_rowmem (
        .i_clk     (i_clk),
        .i_we      (accept),
        .i_wr_addr (wr_cnt),
        .i_wr_data (i_data),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

endmodule

// File: doc/vsq_buffer.md
VSQ_BUFFER -- requirements
Module: vsq_buffer

Interface
REQ-001 SHALL expose these parameters:
  - LANES, 16, lanes per row
  - DW, 40, bits per lane (two's complement)
  - DEPTH, 64, rows per block
REQ-002 SHALL use one clock, i_clk, with synchronous active-high reset i_rst.
REQ-003 SHALL expose these ports (clock and reset first):
  - i_clk  in  1  clock
  - i_rst  in  1  synchronous active-high reset
  - i_valid  in  1  upstream row valid
  - i_data  in  LANES*DW  post-ReLU row, lane g at [g*DW +: DW]
  - o_ready  out  1  row accepted when i_valid && o_ready
  - o_max_data  out  LANES*DW  equals i_data on an accepted write, otherwise all-zero; feeds the quantizer running max
  - o_start  out  1  one-cycle block-full pulse to the quantizer
  - i_rd_addr  in  6  quantizer read row
  - o_rd_data  out  LANES*DW  row at i_rd_addr, combinational
  - o_busy  out  1  high when not accepting rows (block pending or draining)
  - o_ovf  out  1  sticky overflow flag (only when VSQ_BUF_OVF_EN is defined)

Function
REQ-004 SHALL implement states S_FILL, S_START and S_DRAIN.
REQ-005 S_FILL: o_ready=1; each accepted write stores i_data at address wr_cnt, then wr_cnt increments.
REQ-006 An accepted write with wr_cnt==DEPTH-1 SHALL move the block to S_START on the next edge; wr_cnt wraps to 0.
REQ-007 S_START SHALL last exactly one cycle with o_start=1 and o_ready=0, then go to S_DRAIN with drain_cnt=0.
REQ-008 S_DRAIN SHALL hold o_ready=0 for exactly DEPTH cycles (drain_cnt 0..63) and return to S_FILL after drain_cnt==63.
REQ-009 Consequence of REQ-007/008: if the last row is accepted in cycle T, o_start is high in T+1, the quantizer reads in T+2..T+65, and the first new write is accepted in T+66.
REQ-010 o_start SHALL be a registered output, never high for two consecutive cycles.
REQ-011 o_max_data SHALL be zero whenever o_ready=0, so a stalled or invalid input never disturbs the downstream maximum.
REQ-012 o_rd_data SHALL be a combinational read of the row array.
REQ-013 Row storage SHALL change only on accepted writes; rows stay stable throughout S_START and S_DRAIN.
REQ-014 o_busy SHALL equal (state != S_FILL).
REQ-015 i_rd_addr SHALL be ignored for control purposes; reads are legal in any state.
REQ-016 A partially filled block (wr_cnt < DEPTH) SHALL never raise o_start.

Reset
REQ-017 While i_rst=1 the block SHALL hold: state=S_FILL, wr_cnt=0, drain_cnt=0, o_start=0, o_ready=0, o_max_data=0, o_ovf=0.
REQ-018 Reset asserted mid-fill or mid-drain SHALL discard the block in progress; o_start SHALL NOT be raised for it.
REQ-019 Row storage SHALL NOT be reset; o_rd_data for an unwritten row is undefined.

Configuration
REQ-020 Macro VSQ_BUF_OVF_EN defined: o_ovf sets on any cycle with i_valid=1 and o_ready=0 (i_rst=0), and clears only on i_rst.
REQ-021 VSQ_BUF_OVF_EN undefined: port o_ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-022 Shared package vsq_pkg SHALL hold LANES, DW, DEPTH, AW=$clog2(DEPTH) and the state encodings (S_FILL, S_START, S_DRAIN), shared with the quantizer.
REQ-023 Row storage SHALL be a sub-module vsq_rowmem: DEPTH x LANES*DW, one synchronous write port, one asynchronous read port, no reset.
REQ-024 The FSM, counters and o_max_data gating SHALL live in vsq_buffer.

Verification
REQ-025 Write rows k=0..63 (lane g = k*16+g) with i_valid held high -> o_start pulses exactly once, one cycle after row 63; i_rd_addr=5 then returns lane g = 80+g.
REQ-026 Keep i_valid high continuously -> o_ready low for exactly 65 cycles after row 63; the next accepted row lands at address 0.
REQ-027 Drive lane 3 = -7 (two's complement) on an accepted write -> o_max_data lane 3 = -7; the same input with o_ready=0 -> o_max_data all-zero.
REQ-028 Assert i_rst for 1 cycle after 40 rows, then write 64 rows -> o_start appears only after the 64th post-reset row.
REQ-029 With VSQ_BUF_OVF_EN defined, assert i_valid during S_DRAIN -> o_ovf=1 and stays 1 until i_rst; stored rows are unchanged.
REQ-030 Drive gapped i_valid (1 of every 3 cycles) -> o_start follows exactly 64 accepted rows, and row order is preserved.
